enemy_fire_arbiter: RTL and testbench

Decides which enemy column may fire the single enemy bullet. Each column raises a request when it has a live ship and its own bullet delay has elapsed. The arbiter grants one column at a time with round-robin fairness, tracks the bullet while it is in flight, and enforces a frame-counted cooldown before the next shot. It sits between the enemy columns and the enemy-bullet datapath, under the top-level game controller.

---
 rtl/enemy_fire_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_enemy_fire_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_fire_arbiter.sv
// enemy_fire_arbiter
//   Chooses which enemy column fires the single enemy bullet. Columns are
//   picked round-robin. While the bullet is in flight no other column is
//   granted, and after the bullet ends a cooldown counted in frames must pass
//   before the next shot.
//
// Ports
//   clk_i          system clock
//   reset_i        asynchronous active-high reset
//   enable_i       game running; low parks the arbiter in IDLE
//   frame_i        one-cycle pulse per video frame (cooldown timebase)
//   req_i          per-column fire request (level, not latched)
//   bullet_done_i  one-cycle pulse: the active enemy bullet has ended
//   grant_o        one-hot, one-cycle grant pulse
//   grant_id_o     index of the last granted column, held between grants
//   busy_o         enemy bullet in flight
//   state_o        debug state: IDLE=0, ARB=1, FLIGHT=2, COOLDOWN=3
//
// Build option
//   ENEMY_FIRE_LFSR_EN: when defined, an 8-bit LFSR (x^8+x^6+x^5+x^4+1,
//   seed 8'hA5) randomises the search start whenever its low nibble names a
//   real column. When undefined the arbiter is pure round-robin.

module enemy_fire_arbiter #(
  parameter int num_columns_p     = 8,
  parameter int cooldown_frames_p = 30
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     frame_i,
  input  logic [num_columns_p-1:0] req_i,
  input  logic                     bullet_done_i,
  output logic [num_columns_p-1:0] grant_o,
  output logic [3:0]               grant_id_o,
  output logic                     busy_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARB      = 2'd1,
    FLIGHT   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [3:0] last_idx_c = 4'(num_columns_p - 1);
  localparam logic [4:0] num_cols_c = 5'(num_columns_p);
  localparam logic [7:0] cooldown_c = 8'(cooldown_frames_p);

  state_t                   state_reg, state_next;
  logic [3:0]               pointer_reg, pointer_next;
  logic [7:0]               count_reg, count_next;
  logic [num_columns_p-1:0] grant_reg, grant_next;
  logic [3:0]               grant_id_reg, grant_id_next;

  logic [3:0]               search_start;
  logic [15:0]              req_pad;
  logic [4:0]               scan_idx;
  logic [3:0]               pick;
  logic                     pick_valid;
  logic [num_columns_p-1:0] pick_onehot;

`ifdef ENEMY_FIRE_LFSR_EN
  logic [7:0] lfsr_reg;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_reg <= 8'hA5;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
    end
  end

  // A nibble naming a nonexistent column falls back to the round-robin pointer,
  // so the search start is always a valid column index.
  assign search_start = ({1'b0, lfsr_reg[3:0]} < num_cols_c) ? lfsr_reg[3:0] : pointer_reg;
`else
  assign search_start = pointer_reg;
`endif

  // Widen the request vector to 16 bits so the scan can index with a fixed
  // 4-bit index for any column count.
  always_comb begin
    req_pad                    = '0;
    req_pad[num_columns_p-1:0] = req_i;
  end

  // Circular scan starting at search_start; the first set request wins.
  // search_start < num_columns_p, so one subtraction is enough to wrap.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    scan_idx   = '0;
    for (int i = 0; i < num_columns_p; i++) begin
      scan_idx = {1'b0, search_start} + 5'(i);
      if (scan_idx >= num_cols_c) begin
        scan_idx = scan_idx - num_cols_c;
      end
      if (!pick_valid && req_pad[scan_idx[3:0]]) begin
        pick_valid = 1'b1;
        pick       = scan_idx[3:0];
      end
    end
  end

  for (genvar gi = 0; gi < num_columns_p; gi++) begin : g_onehot
    assign pick_onehot[gi] = (pick == 4'(gi));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg    <= IDLE;
      pointer_reg  <= '0;
      count_reg    <= '0;
      grant_reg    <= '0;
      grant_id_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pointer_reg  <= pointer_next;
      count_reg    <= count_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pointer_next  = pointer_reg;
    count_next    = count_reg;
    grant_next    = '0;
    grant_id_next = grant_id_reg;
    case (state_reg)
      IDLE: begin
        if (enable_i) begin
          state_next = ARB;
        end
      end
      ARB: begin
        if (!enable_i) begin
          state_next = IDLE;
        end else if (pick_valid) begin
          grant_next    = pick_onehot;
          grant_id_next = pick;
          pointer_next  = (pick == last_idx_c) ? 4'd0 : pick + 4'd1;
          state_next    = FLIGHT;
        end
      end
      FLIGHT: begin
        // Dropping enable_i does not abort the bullet; only bullet_done_i ends it.
        // A frame pulse in this cycle is not counted because the counter is
        // loaded rather than decremented here.
        if (bullet_done_i) begin
          if (!enable_i) begin
            state_next = IDLE;
          end else if (cooldown_c == 8'd0) begin
            state_next = ARB;
          end else begin
            state_next = COOLDOWN;
            count_next = cooldown_c;
          end
        end
      end
      COOLDOWN: begin
        if (!enable_i) begin
          state_next = IDLE;
          count_next = '0;
        end else if (frame_i) begin
          if (count_reg <= 8'd1) begin
            state_next = ARB;
            count_next = '0;
          end else begin
            count_next = count_reg - 8'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign grant_o    = grant_reg;
  assign grant_id_o = grant_id_reg;
  assign busy_o     = (state_reg == FLIGHT);
  assign state_o    = state_reg;

endmodule

// File: tb/tb_enemy_fire_arbiter.sv
// Testbench for enemy_fire_arbiter with four columns and a two-frame cooldown.
// Expected grant indices are queued when stimulus is issued; a monitor pops
// and compares whenever a grant pulse appears.

module tb_enemy_fire_arbiter;

  localparam int N  = 4;
  localparam int CD = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         frame;
  logic [N-1:0] req;
  logic         bullet_done;
  logic [N-1:0] grant;
  logic [3:0]   grant_id;
  logic         busy;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int hits[N];

  enemy_fire_arbiter #(
    .num_columns_p(N),
    .cooldown_frames_p(CD)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .enable_i(enable),
    .frame_i(frame),
    .req_i(req),
    .bullet_done_i(bullet_done),
    .grant_o(grant),
    .grant_id_o(grant_id),
    .busy_o(busy),
    .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Monitor: every grant pulse must match the next queued expectation.
  always @(negedge clk) begin
    int e;
    if (grant !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant got %b expected none", grant);
      end else begin
        e = exp_q.pop_front();
        check("grant_vec", 32'(grant), 32'(1 << e));
        check("grant_id", 32'(grant_id), 32'(e));
        check("grant_busy", 32'(busy), 32'd1);
        check("grant_state", 32'(state), 32'd2);
      end
    end
  end

`ifdef ENEMY_FIRE_LFSR_EN
  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 8'hA5, advancing every cycle.
  logic [7:0] lfsr_m;
  int         ptr_m;

  always @(posedge clk or posedge reset) begin
    if (reset) lfsr_m <= 8'hA5;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  // Predictor: in an ARB cycle with requests pending, compute the pick.
  always @(negedge clk) begin
    int start;
    int idx;
    int w;
    if (reset) begin
      ptr_m = 0;
    end else if (state == 2'd1 && enable && req != '0) begin
      start = (int'(lfsr_m[3:0]) < N) ? int'(lfsr_m[3:0]) : ptr_m;
      w = -1;
      for (int i = 0; i < N; i++) begin
        idx = (start + i) % N;
        if (w < 0 && req[idx]) w = idx;
      end
      exp_q.push_back(w);
      hits[w]++;
      ptr_m = (w + 1) % N;
    end
  end
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_flight();
    int n = 0;
    while (state !== 2'd2 && n < 20) begin
      tick();
      n++;
    end
    check("wait_flight", 32'(state), 32'd2);
  endtask

  // End the current bullet and walk the cooldown, checking each step.
  task automatic finish_bullet(input bit coincident);
    bullet_done = 1'b1;
    frame       = coincident;
    tick();
    bullet_done = 1'b0;
    frame       = 1'b0;
    check("cd_entry_state", 32'(state), 32'd3);
    check("cd_entry_busy", 32'(busy), 32'd0);
    tick();
    tick();
    check("cd_hold", 32'(state), 32'd3);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check("cd_after_frame1", 32'(state), 32'd3);
    tick();
    check("cd_wait", 32'(state), 32'd3);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check("cd_after_frame2", 32'(state), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    frame       = 1'b0;
    bullet_done = 1'b0;
    req         = '0;
    for (int c = 0; c < N; c++) hits[c] = 0;
    do_reset();

    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);

`ifdef ENEMY_FIRE_LFSR_EN
    enable = 1'b1;
    req    = 4'b1111;
    for (int k = 0; k < 64; k++) begin
      wait_flight();
      finish_bullet(1'b0);
    end
    req = '0;
    tick();
    tick();
    for (int c = 0; c < N; c++) check("lfsr_col_hit", 32'(hits[c] >= 1), 32'd1);
`else
    // First grant: pointer 0, requests on columns 1 and 3 -> column 1.
    exp_q.push_back(1);
    enable = 1'b1;
    req    = 4'b1010;
    wait_flight();
    req = '0;
    finish_bullet(1'b0);

    // Fairness from a fresh reset: 0,1,2,3 then wrap to 0.
    do_reset();
    req = 4'b1111;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    for (int k = 0; k < 4; k++) begin
      wait_flight();
      finish_bullet(k == 1);
    end
    wait_flight();
    tick();
    check("id_held_after_wrap", 32'(grant_id), 32'd0);

    // Enable dropped in flight: bullet survives, then arbiter parks.
    enable = 1'b0;
    tick();
    tick();
    check("drop_busy", 32'(busy), 32'd1);
    check("drop_state", 32'(state), 32'd2);
    bullet_done = 1'b1;
    tick();
    bullet_done = 1'b0;
    check("parked_state", 32'(state), 32'd0);
    check("parked_busy", 32'(busy), 32'd0);
    repeat (10) tick();
    check("parked_still", 32'(state), 32'd0);

    // Reset in the middle of a flight takes effect without a clock edge.
    enable = 1'b1;
    exp_q.push_back(1);
    wait_flight();
    tick();
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_grant_id", 32'(grant_id), 32'd0);
    tick();
    reset = 1'b0;
    req   = 4'b0001;
    exp_q.push_back(0);
    wait_flight();
    tick();
    check("post_rst_busy", 32'(busy), 32'd1);
`endif

    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
